bid_agent: RTL and testbench

- Autonomous bidder-side engine that drives one bidder channel of the auction controller: bid request, bid amount and retract.
- It consumes the controller's ack, error, balance, maxBid, roundOver and win responses.
- Armed by the host with a step and a spending limit, it outbids the current maximum until it wins, hits its limit, or the round ends.
- One instance sits in front of each of the X/Y/Z bidder ports in the system-level bench and emulation top.

---
 rtl/bid_agent.sv | 185 ++++++++++++++++++
 tb/tb_bid_agent.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bid_agent.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bid_agent                                               |
// | Purpose  : Autonomous bidder engine for one auction controller     |
// |            bidder channel. Outbids the current maximum by a        |
// |            configured step until it leads, runs out of budget or   |
// |            the round ends; supports retraction of the last bid.    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module bid_agent #(
  parameter int AMT_W     = 16,
  parameter int VAL_W     = 32,
  parameter int MAX_RETRY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic [AMT_W-1:0] cfg_step,
  input  logic [VAL_W-1:0] cfg_limit,
  input  logic             abort,
  input  logic             round_start,
  output logic             bid,
  output logic [AMT_W-1:0] bid_amt,
  output logic             retract,
  input  logic             ack,
  input  logic [1:0]       err,
  input  logic [VAL_W-1:0] balance,
  input  logic [VAL_W-1:0] max_bid,
  input  logic             round_over,
  input  logic             win,
  output logic [VAL_W-1:0] total_bid,
  output logic [7:0]       bids_sent,
  output logic [1:0]       last_err,
  output logic             won,
  output logic             done,
  output logic             busy
);

  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_armed   = 3'd1;
  localparam logic [2:0] c_st_eval    = 3'd2;
  localparam logic [2:0] c_st_issue   = 3'd3;
  localparam logic [2:0] c_st_watch   = 3'd4;
  localparam logic [2:0] c_st_retract = 3'd5;
  localparam logic [2:0] c_st_hold    = 3'd6;
  localparam logic [2:0] c_st_result  = 3'd7;

  localparam logic [VAL_W:0] c_amt_max = {{(VAL_W+1-AMT_W){1'b0}}, {AMT_W{1'b1}}};

  logic [2:0]       r_state;
  logic [AMT_W-1:0] r_step;
  logic [VAL_W-1:0] r_limit;
  logic [AMT_W-1:0] r_amt;
  logic [AMT_W-1:0] r_last_amt;
  logic [RTY_W-1:0] r_retry;
  logic [VAL_W-1:0] r_total;
  logic [7:0]       r_bids;
  logic [1:0]       r_last_err;
  logic             r_won;
  logic             r_done;

  logic [VAL_W:0]   w_diff;
  logic [AMT_W-1:0] w_amt;
  logic [VAL_W:0]   w_sum;
  logic             w_over_limit;
  logic             w_no_funds;
  logic [RTY_W-1:0] w_retry_next;
  logic [VAL_W-1:0] w_last_ext;

  // Outbid amount: gap to the current maximum plus step, clipped to the bid port width
  assign w_diff       = {1'b0, max_bid} - {1'b0, r_total} + {{(VAL_W+1-AMT_W){1'b0}}, r_step};
  assign w_amt        = (w_diff > c_amt_max) ? {AMT_W{1'b1}} : w_diff[AMT_W-1:0];
  assign w_sum        = {1'b0, r_total} + {{(VAL_W+1-AMT_W){1'b0}}, w_amt};
  assign w_over_limit = w_sum > {1'b0, r_limit};
  assign w_no_funds   = {{(VAL_W-AMT_W){1'b0}}, w_amt} >= balance;
  assign w_retry_next = r_retry + 1'b1;
  assign w_last_ext   = {{(VAL_W-AMT_W){1'b0}}, r_last_amt};

  // Requests are decoded from state so an async reset drops them immediately
  assign bid       = (r_state == c_st_issue);
  assign retract   = (r_state == c_st_retract);
  assign bid_amt   = bid ? r_amt : (retract ? r_last_amt : '0);
  assign busy      = (r_state != c_st_idle);
  assign total_bid = r_total;
  assign bids_sent = r_bids;
  assign last_err  = r_last_err;
  assign won       = r_won;
  assign done      = r_done;

  // Round sequencer and bookkeeping registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_st_idle;
      r_step     <= '0;
      r_limit    <= '0;
      r_amt      <= '0;
      r_last_amt <= '0;
      r_retry    <= '0;
      r_total    <= '0;
      r_bids     <= '0;
      r_last_err <= '0;
      r_won      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (cfg_en) begin
            r_step     <= cfg_step;
            r_limit    <= cfg_limit;
            r_total    <= '0;
            r_bids     <= '0;
            r_last_err <= '0;
            r_last_amt <= '0;
            r_retry    <= '0;
            r_state    <= c_st_armed;
          end
        end
        c_st_armed: begin
          if (round_over)       r_state <= c_st_idle;
          else if (round_start) r_state <= c_st_eval;
        end
        c_st_eval: begin
          if (round_over)                      r_state <= c_st_result;
          else if (r_total > max_bid)          r_state <= c_st_watch;
          else if (w_over_limit || w_no_funds) r_state <= c_st_hold;
          else begin
            r_amt   <= w_amt;
            r_state <= c_st_issue;
          end
        end
        c_st_issue: begin
          if (round_over) begin
            r_state <= c_st_result;
          end else if (err != 2'b00) begin
            r_last_err <= err;
            r_state    <= c_st_hold;
          end else if (ack) begin
            r_total    <= r_total + {{(VAL_W-AMT_W){1'b0}}, r_amt};
            r_last_amt <= r_amt;
            r_retry    <= '0;
            if (r_bids != 8'hFF) r_bids <= r_bids + 8'd1;
            r_state    <= c_st_watch;
          end else begin
            r_retry <= w_retry_next;
            if (w_retry_next == RTY_W'(MAX_RETRY)) r_state <= c_st_hold;
          end
        end
        c_st_watch: begin
          if (round_over)                         r_state <= c_st_result;
          else if (abort && (r_last_amt != '0))   r_state <= c_st_retract;
          else if (max_bid > r_total)             r_state <= c_st_eval;
        end
        c_st_retract: begin
          r_total    <= (r_total >= w_last_ext) ? (r_total - w_last_ext) : '0;
          r_last_amt <= '0;
          r_state    <= c_st_hold;
        end
        c_st_hold: begin
          if (round_over) r_state <= c_st_result;
        end
        default: begin
          r_won  <= win;
          r_done <= 1'b1;
          if (cfg_en) begin
            r_step     <= cfg_step;
            r_limit    <= cfg_limit;
            r_total    <= '0;
            r_bids     <= '0;
            r_last_err <= '0;
            r_last_amt <= '0;
            r_retry    <= '0;
            r_state    <= c_st_armed;
          end else begin
            r_state <= c_st_idle;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bid_agent.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_bid_agent                                            |
// | Purpose  : Self-checking bench for bid_agent: directed scenarios   |
// |            plus randomized rounds against a transaction model.     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_bid_agent;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_en = 1'b0;
  logic [15:0] cfg_step = '0;
  logic [31:0] cfg_limit = '0;
  logic        abort = 1'b0;
  logic        round_start = 1'b0;
  logic        bid;
  logic [15:0] bid_amt;
  logic        retract;
  logic        ack;
  logic [1:0]  err;
  logic [31:0] balance = '0;
  logic [31:0] max_bid = '0;
  logic        round_over = 1'b0;
  logic        win = 1'b0;
  logic [31:0] total_bid;
  logic [7:0]  bids_sent;
  logic [1:0]  last_err;
  logic        won;
  logic        done;
  logic        busy;

  logic        ack_en = 1'b0;
  logic [1:0]  err_drv = 2'b00;

  int errors = 0;
  int checks = 0;

  bid_agent dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_step(cfg_step),
    .cfg_limit(cfg_limit), .abort(abort), .round_start(round_start),
    .bid(bid), .bid_amt(bid_amt), .retract(retract), .ack(ack), .err(err),
    .balance(balance), .max_bid(max_bid), .round_over(round_over), .win(win),
    .total_bid(total_bid), .bids_sent(bids_sent), .last_err(last_err),
    .won(won), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Controller emulation: same-cycle response to a bid request
  always_comb begin
    ack = ack_en & bid;
    err = bid ? err_drv : 2'b00;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [15:0] step, input logic [31:0] limit);
    cfg_step  = step;
    cfg_limit = limit;
    cfg_en    = 1'b1;
    tick();
    cfg_en    = 1'b0;
  endtask

  task automatic wait_bid(input int n, output bit seen, output logic [15:0] amt);
    seen = 1'b0;
    amt  = '0;
    for (int i = 0; i < n; i++) begin
      if (bid) begin
        seen = 1'b1;
        amt  = bid_amt;
        return;
      end
      tick();
    end
  endtask

  task automatic finish_round(input logic win_v, input logic [31:0] exp_total, input string tag);
    bit seen;
    seen       = 1'b0;
    round_over = 1'b1;
    win        = win_v;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_done"}, seen, 1'b1);
    chk({tag, "_won"}, won, win_v);
    chk({tag, "_total"}, total_bid, exp_total);
    tick();
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
    round_over  = 1'b0;
    win         = 1'b0;
    round_start = 1'b0;
  endtask

  initial begin
    bit          seen;
    logic [15:0] amt;
    int          cnt;
    longint      step_m, limit_m, bal_m, max_m, tot_m, diff_m;
    int          sent_m;
    bit          held, first, need, expect_bid;
    logic        win_v;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_bid", bid, 1'b0);
    chk("rst_retract", retract, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_total", total_bid, 32'd0);
    chk("rst_sent", bids_sent, 8'd0);
    chk("rst_won", won, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_amt", bid_amt, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_wait", busy, 1'b0);

    // ---- basic outbidding then budget hold ----
    balance = 32'd1000; max_bid = 32'd0; ack_en = 1'b1; round_start = 1'b1;
    arm(16'd5, 32'd100);
    chk("t1_busy", busy, 1'b1);
    wait_bid(6, seen, amt);
    chk("t1_bid1_seen", seen, 1'b1);
    chk("t1_bid1_amt", amt, 16'd5);
    tick();
    chk("t1_bid1_pulse", bid, 1'b0);
    chk("t1_total1", total_bid, 32'd5);
    chk("t1_sent1", bids_sent, 8'd1);
    max_bid = 32'd20;
    wait_bid(6, seen, amt);
    chk("t1_bid2_seen", seen, 1'b1);
    chk("t1_bid2_amt", amt, 16'd20);
    tick();
    chk("t1_total2", total_bid, 32'd25);
    max_bid = 32'd98;
    wait_bid(8, seen, amt);
    chk("t1_limit_hold", seen, 1'b0);
    finish_round(1'b0, 32'd25, "t1");

    // ---- retraction ----
    max_bid = 32'd0; round_start = 1'b1;
    arm(16'd5, 32'd100);
    wait_bid(6, seen, amt);
    chk("t2_bid_amt", amt, 16'd5);
    tick();
    chk("t2_total", total_bid, 32'd5);
    abort = 1'b1;
    for (int i = 0; i < 8 && !retract; i++) tick();
    chk("t2_retract", retract, 1'b1);
    chk("t2_retract_amt", bid_amt, 16'd5);
    chk("t2_no_bid", bid, 1'b0);
    tick();
    abort = 1'b0;
    chk("t2_retract_pulse", retract, 1'b0);
    chk("t2_total_after", total_bid, 32'd0);
    max_bid = 32'd50;
    wait_bid(8, seen, amt);
    chk("t2_hold", seen, 1'b0);
    finish_round(1'b0, 32'd0, "t2");

    // ---- masked error ----
    max_bid = 32'd0; round_start = 1'b1; ack_en = 1'b0; err_drv = 2'b11;
    arm(16'd5, 32'd100);
    wait_bid(6, seen, amt);
    chk("t3_bid_seen", seen, 1'b1);
    tick();
    chk("t3_last_err", last_err, 2'b11);
    max_bid = 32'd50;
    wait_bid(10, seen, amt);
    chk("t3_no_more_bids", seen, 1'b0);
    finish_round(1'b0, 32'd0, "t3");
    chk("t3_last_err_kept", last_err, 2'b11);
    err_drv = 2'b00;

    // ---- retry exhaustion ----
    max_bid = 32'd0; round_start = 1'b1; ack_en = 1'b0;
    arm(16'd5, 32'd100);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (bid) cnt++;
      tick();
    end
    chk("t4_bid_cycles", cnt, 4);
    chk("t4_sent", bids_sent, 8'd0);
    finish_round(1'b0, 32'd0, "t4");

    // ---- randomized rounds against a transaction-level model ----
    ack_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      step_m  = longint'($urandom_range(1, 40));
      limit_m = longint'($urandom_range(40, 600));
      bal_m   = longint'($urandom_range(20, 2000));
      max_m   = longint'($urandom_range(0, 30));
      balance = 32'(bal_m);
      max_bid = 32'(max_m);
      tot_m = 0; sent_m = 0; held = 1'b0; first = 1'b1;
      round_start = 1'b1;
      arm(16'(step_m), 32'(limit_m));
      for (int k = 0; k < 8; k++) begin
        if (!first) begin
          max_m   = tot_m + longint'($urandom_range(0, 60));
          max_bid = 32'(max_m);
        end
        need       = first || (max_m > tot_m);
        diff_m     = max_m - tot_m + step_m;
        if (diff_m > 65535) diff_m = 65535;
        expect_bid = need && !held && (tot_m + diff_m <= limit_m) && (diff_m < bal_m);
        if (need && !held && !expect_bid) held = 1'b1;
        wait_bid(8, seen, amt);
        chk("rnd_bid_seen", seen, expect_bid);
        if (seen && expect_bid) begin
          chk("rnd_bid_amt", amt, 16'(diff_m));
          chk("rnd_no_retract", retract, 1'b0);
          tick();
          tot_m += diff_m;
          sent_m++;
          chk("rnd_total", total_bid, 32'(tot_m));
          chk("rnd_sent", bids_sent, 8'(sent_m));
        end
        first = 1'b0;
      end
      win_v = 1'($urandom_range(0, 1));
      finish_round(win_v, 32'(tot_m), "rnd");
    end

    // ---- amount clipping, winning round ----
    balance = 32'hFFFF_FFFF; max_bid = 32'd100000; round_start = 1'b1; ack_en = 1'b1;
    arm(16'd10, 32'hFFFF_FFFF);
    wait_bid(6, seen, amt);
    chk("t6_clip_amt", amt, 16'hFFFF);
    tick();
    chk("t6_total1", total_bid, 32'd65535);
    wait_bid(6, seen, amt);
    chk("t6_amt2", amt, 16'd34475);
    tick();
    chk("t6_total2", total_bid, 32'd100010);
    finish_round(1'b1, 32'd100010, "t6");

    // ---- asynchronous reset in the middle of a request ----
    max_bid = 32'd0; round_start = 1'b1; ack_en = 1'b0;
    arm(16'd5, 32'd100);
    wait_bid(6, seen, amt);
    chk("t5_in_issue", seen, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_bid", bid, 1'b0);
    chk("t5_retract", retract, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_won", won, 1'b0);
    chk("t5_amt", bid_amt, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    round_start = 1'b0;
    repeat (5) tick();
    chk("t5_idle_after", busy, 1'b0);
    arm(16'd5, 32'd100);
    chk("t5_rearm", busy, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
